// File: rtl/boutons_pkg.sv
// Shared constants and FSM encoding for the push-button conditioner.
// Optional event pulses are enabled with `define BOUTONS_EVENT_EN.
package boutons_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_e;

  localparam int DEF_NB_BTN          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/boutons_debounce_if.sv
// Pin-side bundle: raw pins in, clean levels (and optional events) out.
// btn_press/btn_release exist only with `define BOUTONS_EVENT_EN.
interface boutons_debounce_if
  import boutons_pkg::*;
#(
  parameter int NB_BTN = DEF_NB_BTN
);

  logic [NB_BTN-1:0] btn_raw;
  logic [NB_BTN-1:0] btn_clean;
`ifdef BOUTONS_EVENT_EN
  logic [NB_BTN-1:0] btn_press;
  logic [NB_BTN-1:0] btn_release;
`endif

  modport master (
    output btn_raw,
`ifdef BOUTONS_EVENT_EN
    input  btn_press,
    input  btn_release,
`endif
    input  btn_clean
  );

  modport slave (
    input  btn_raw,
`ifdef BOUTONS_EVENT_EN
    output btn_press,
    output btn_release,
`endif
    output btn_clean
  );

endinterface

// File: rtl/boutons_debounce_bit.sv
// One button: 2-FF synchronizer, polarity fold, counter debounce FSM.
// Output is 1 = pressed and only moves after a full stable window.
module boutons_debounce_bit
  import boutons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_clean;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clean_nxt;
  logic             w_lvl;

  // Pin's idle level folds to 0, so lvl is always 1 = pressed
  assign w_lvl = r_sync2 ^ REL_LVL;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    unique case (r_state)
      ST_STABLE: begin
        if (w_lvl != r_clean) begin
          w_state_nxt = ST_COUNT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_COUNT: begin
        if (w_lvl == r_clean) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_clean_nxt = w_lvl;
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/boutons_debounce.sv
// Debounces NB_BTN raw pins for the button PIO in_port.
// `define BOUTONS_EVENT_EN adds 1-cycle press/release pulses.
module boutons_debounce
  import boutons_pkg::*;
#(
  parameter int NB_BTN          = DEF_NB_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  boutons_debounce_if.slave  bus
);

  logic [NB_BTN-1:0] w_clean;

  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    boutons_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_raw   (bus.btn_raw[g]),
      .o_clean (w_clean[g])
    );
  end

  assign bus.btn_clean = w_clean;

`ifdef BOUTONS_EVENT_EN
  logic [NB_BTN-1:0] r_clean_q;
  logic [NB_BTN-1:0] r_press;
  logic [NB_BTN-1:0] r_release;

  // Edge detect on the clean level; q resets to 0 so reset exit is silent
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clean_q <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_clean_q <= w_clean;
      r_press   <= w_clean & ~r_clean_q;
      r_release <= ~w_clean & r_clean_q;
    end
  end

  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
`endif

endmodule

// File: tb/tb_boutons_debounce.sv
// Scoreboarded random/directed bench for boutons_debounce.
// Event outputs are checked when BOUTONS_EVENT_EN is defined.
module tb_boutons_debounce;
  import boutons_pkg::*;

  localparam int NB   = 2;
  localparam int D    = SIM_DEBOUNCE_CYCLES;
  localparam int AL   = 1;
  localparam int MAXE = 8192;

  typedef struct packed {
    logic [NB-1:0] clean;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  boutons_debounce_if #(.NB_BTN(NB)) bif ();

  boutons_debounce #(
    .NB_BTN          (NB),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  exp_t          expq[$];
  int            checks = 0;
  int            errors = 0;
  int            edge_n = 0;
  logic          hist[NB][MAXE];
  logic [NB-1:0] mclean[MAXE];
  int            lastflip[NB];

  task automatic chk(string nm, logic [NB-1:0] act,
                     logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b",
               nm, $time, act, exp);
    end
  endtask

  // Reference: a button's level flips once its pressed-level,
  // seen two clocks late, has disagreed with the current output
  // for D consecutive edges, all later than the last flip/reset.
  task automatic model_step();
    exp_t x;
    int   e;
    logic p;
    logic cur;
    bit   ok;
    e = edge_n;
    x = '0;
    for (int b = 0; b < NB; b++) begin
      p = (AL != 0) ? ~bif.btn_raw[b] : bif.btn_raw[b];
      if (!reset_n) begin
        hist[b][e] = 1'b0;
        if (e > 0) hist[b][e-1] = 1'b0;
        lastflip[b] = e;
        x.clean[b]  = 1'b0;
      end else begin
        hist[b][e] = p;
        cur = (e > 0) ? mclean[e-1][b] : 1'b0;
        ok  = (e - lastflip[b] >= D);
        for (int k = 0; k < D; k++) begin
          if (e - 2 - k < 0) ok = 0;
          else if (hist[b][e-2-k] == cur) ok = 0;
        end
        x.clean[b] = ok ? ~cur : cur;
        if (ok) lastflip[b] = e;
      end
    end
    mclean[e] = x.clean;
    if (reset_n && e >= 2) begin
      x.press = mclean[e-1] & ~mclean[e-2];
      x.rel   = ~mclean[e-1] & mclean[e-2];
    end
    expq.push_back(x);
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL model_overflow edges=%0d limit=%0d",
               edge_n, MAXE);
      $fatal(1);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t x;
    @(negedge clk);
    if (expq.size() > 0) begin
      x = expq.pop_front();
      chk("clean", bif.btn_clean, x.clean);
`ifdef BOUTONS_EVENT_EN
      chk("press", bif.btn_press, x.press);
      chk("release", bif.btn_release, x.rel);
`endif
    end
  end

  // Edges from the pin change until btn_clean[b] reaches want
  task automatic lat(string nm, int b, logic want, int expn);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bif.btn_clean[b] === want) break;
    end
    checks++;
    if (bif.btn_clean[b] !== want || n != expn) begin
      errors++;
      $display("FAIL %s got_cycles=%0d want_cycles=%0d",
               nm, n, expn);
    end
  endtask

  int hold[NB];

  initial begin
    reset_n     = 1'b0;
    bif.btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);

    // bounce shorter than the window
    bif.btn_raw[0] = 1'b0;
    repeat (3) @(negedge clk);
    bif.btn_raw[0] = 1'b1;
    repeat (10) @(negedge clk);

    // simultaneous press
    bif.btn_raw = 2'b00;
    lat("press_both_lat", 0, 1'b1, 2 + D);
    repeat (4) @(negedge clk);

    // release of button 1
    bif.btn_raw[1] = 1'b1;
    lat("release1_lat", 1, 1'b0, 2 + D);
    repeat (4) @(negedge clk);
    bif.btn_raw[0] = 1'b1;
    repeat (12) @(negedge clk);

    // single press
    bif.btn_raw[0] = 1'b0;
    lat("press0_lat", 0, 1'b1, 2 + D);
    repeat (4) @(negedge clk);
    bif.btn_raw[0] = 1'b1;
    repeat (12) @(negedge clk);

    // reset in the middle of a count
    bif.btn_raw[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_clean", bif.btn_clean, 2'b00);
    reset_n = 1'b1;
    lat("rst_requal_lat", 0, 1'b1, 2 + D);
    repeat (6) @(negedge clk);

    // random bouncing pins, occasional reset
    for (int b = 0; b < NB; b++) hold[b] = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        reset_n = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          bif.btn_raw[b] = ~bif.btn_raw[b];
          hold[b] = $urandom_range(1, 2 * D + 4);
        end
      end
    end

    repeat (D + 4) @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
